// File: rtl/arbiter_rr_param.sv
// N-way round-robin arbiter with registered one-hot grant, grant hold while the
// owner keeps requesting, and a MAX_HOLD burst cap that forces rotation.
module arbiter_rr_param #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 4,
  parameter int IW       = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic          gnt_valid,
  output logic [IW-1:0] gnt_idx
);

  localparam int            HW   = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HW-1:0] HMAX = HW'(MAX_HOLD);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [HW-1:0] hold_cnt;

  logic [N-1:0]  cand;
  logic [IW-1:0] win;
  logic          found;
  logic          own_req;
  logic          cap_hit;

  function automatic logic [IW-1:0] rot(input logic [IW-1:0] p, input int i);
    return IW'((int'(p) + i) % N);
  endfunction

  // In GRANT, ptr is the owner; masking it leaves only the waiting requesters.
  always_comb begin
    cand  = (state == GRANT) ? (req & ~gnt) : req;
    win   = '0;
    found = 1'b0;
    for (int i = 1; i <= N; i++) begin
      if (!found && cand[rot(ptr, i)]) begin
        found = 1'b1;
        win   = rot(ptr, i);
      end
    end
    own_req = (state == GRANT) && req[ptr];
    cap_hit = (MAX_HOLD != 0) && (hold_cnt == HMAX) && found;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_idx   <= '0;
      ptr       <= IW'(N - 1);
      hold_cnt  <= '0;
    end else if (own_req && !cap_hit) begin
      if (MAX_HOLD != 0 && hold_cnt != HMAX)
        hold_cnt <= hold_cnt + 1'b1;
    end else if (found) begin
      // fresh grant, release handoff or forced rotation: all take the search winner
      state     <= GRANT;
      gnt       <= N'(1) << win;
      gnt_valid <= 1'b1;
      gnt_idx   <= win;
      ptr       <= win;
      hold_cnt  <= (MAX_HOLD == 0) ? '0 : HW'(1);
    end else begin
      // ptr and gnt_idx keep the last owner
      state     <= IDLE;
      gnt       <= '0;
      gnt_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_arbiter_rr_param.sv
// Bench for arbiter_rr_param: directed vector table and corner sequences on N=4,
// plus a random sweep of N=2,3,5,8 against a behavioural round-robin model.
module tb_arbiter_rr_param;

  logic clk;
  logic rst_n;
  logic rnd_en;
  int   n_cmp;
  int   n_bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // u0: N=4 MAX_HOLD=4, u1: MAX_HOLD=1, u2: MAX_HOLD=0
  logic [3:0] r0, g0, r1, g1, r2, g2;
  logic       v0, v1, v2;
  logic [1:0] i0, i1, i2;

  arbiter_rr_param #(.N(4), .MAX_HOLD(4)) u0 (.clk(clk), .rst_n(rst_n), .req(r0), .gnt(g0), .gnt_valid(v0), .gnt_idx(i0));
  arbiter_rr_param #(.N(4), .MAX_HOLD(1)) u1 (.clk(clk), .rst_n(rst_n), .req(r1), .gnt(g1), .gnt_valid(v1), .gnt_idx(i1));
  arbiter_rr_param #(.N(4), .MAX_HOLD(0)) u2 (.clk(clk), .rst_n(rst_n), .req(r2), .gnt(g2), .gnt_valid(v2), .gnt_idx(i2));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [3:0] req;
    logic [3:0] gnt;
    logic       vld;
    logic [1:0] idx;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [3:0] rq, input logic [3:0] gn, input logic vl,
                     input logic [1:0] ix, input int reps);
    vec_t v;
    v.req = rq; v.gnt = gn; v.vld = vl; v.idx = ix;
    for (int k = 0; k < reps; k++) tbl.push_back(v);
  endtask

  // Random sweep: each instance has its own stimulus and reference model.
  for (genvar g = 0; g < 4; g++) begin : sw
    localparam int NN  = (g == 0) ? 2 : (g == 1) ? 3 : (g == 2) ? 5 : 8;
    localparam int MH  = g + 1;
    localparam int IWW = $clog2(NN);

    logic [NN-1:0]  rq = '0;
    logic [NN-1:0]  gn;
    logic           gv;
    logic [IWW-1:0] gi;

    arbiter_rr_param #(.N(NN), .MAX_HOLD(MH)) dut (
      .clk(clk), .rst_n(rst_n), .req(rq), .gnt(gn), .gnt_valid(gv), .gnt_idx(gi));

    initial begin : run
      string pfx;
      int r, gg, newr, oth, own, ptr, run, idx, nw, maxw;
      int wt[8];
      pfx = $sformatf("n%0d", NN);
      own = -1; ptr = NN - 1; run = 0; idx = 0; maxw = 0;
      for (int k = 0; k < 8; k++) wt[k] = 0;
      wait (rnd_en);
      while (rnd_en) begin
        @(negedge clk);
        r  = 32'(rq);
        gg = 32'(gn);
        chk({pfx, "_gnt"}, gg, (own < 0) ? 0 : (1 << own));
        chk({pfx, "_vld"}, gv, own >= 0);
        chk({pfx, "_idx"}, gi, idx);
        chk({pfx, "_onehot"}, $onehot0(gn), 1);
        chk({pfx, "_vld_or"}, gv, |gn);
        chk({pfx, "_gnt_wo_req"}, gg & ~r, 0);
        if (gv) chk({pfx, "_idx_vs_gnt"}, 1 << gi, gg);
        for (int k = 0; k < NN; k++) begin
          if (((r >> k) & 1) != 0 && ((gg >> k) & 1) == 0) wt[k]++;
          else wt[k] = 0;
          if (wt[k] > maxw) maxw = wt[k];
        end
        // sticky requests: each bit flips with probability 1/8
        newr = (r ^ int'($urandom & $urandom & $urandom)) & ((1 << NN) - 1);
        oth  = (own >= 0) ? (newr & ~(1 << own)) : newr;
        if (own >= 0 && ((newr >> own) & 1) != 0 && !(run >= MH && oth != 0)) begin
          if (run < MH) run++;
        end else if (oth == 0) begin
          own = -1;
        end else begin
          nw = -1;
          for (int k = 1; k <= NN; k++)
            if (nw < 0 && ((oth >> ((ptr + k) % NN)) & 1) != 0) nw = (ptr + k) % NN;
          own = nw; ptr = nw; idx = nw; run = 1;
        end
        rq = NN'(newr);
      end
      chk({pfx, "_starve_ok"}, maxw <= (NN - 1) * MH + 1, 1);
    end
  end

  logic [3:0] t2_exp[5];

  initial begin
    n_cmp = 0; n_bad = 0; rnd_en = 1'b0;
    r1 = '0; r2 = '0;

    // T1: reset with all requesting
    rst_n = 1'b0; r0 = 4'b1111;
    repeat (2) @(negedge clk);
    chk("t1_rst_gnt", g0, 4'b0000);
    chk("t1_rst_vld", v0, 1'b0);
    chk("t1_rst_idx", i0, 2'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t1_first_gnt", g0, 4'b0001);
    chk("t1_first_idx", i0, 2'd0);

    // T6: owner 2, then async reset between edges
    r0 = 4'b0100;
    @(negedge clk);
    chk("t6_owner2", g0, 4'b0100);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_gnt", g0, 4'b0000);
    chk("t6_async_vld", v0, 1'b0);
    chk("t6_async_idx", i0, 2'd0);
    r0 = 4'b1111;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_after_rel", g0, 4'b0001);

    // Table: handoff/wrap, idle hold of idx, burst cap rotation, sole holder
    add(4'b0000, 4'b0000, 1'b0, 2'd0, 1);
    add(4'b1000, 4'b1000, 1'b1, 2'd3, 1);
    add(4'b0101, 4'b0001, 1'b1, 2'd0, 1);
    add(4'b0000, 4'b0000, 1'b0, 2'd0, 1);
    add(4'b0011, 4'b0010, 1'b1, 2'd1, 4);
    add(4'b0011, 4'b0001, 1'b1, 2'd0, 4);
    add(4'b0011, 4'b0010, 1'b1, 2'd1, 1);
    add(4'b0001, 4'b0001, 1'b1, 2'd0, 7);
    add(4'b1110, 4'b0010, 1'b1, 2'd1, 1);
    add(4'b1100, 4'b0100, 1'b1, 2'd2, 1);
    add(4'b1000, 4'b1000, 1'b1, 2'd3, 1);
    add(4'b0000, 4'b0000, 1'b0, 2'd3, 1);
    rst_n = 1'b0; r0 = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < tbl.size(); k++) begin
      r0 = tbl[k].req;
      @(negedge clk);
      chk($sformatf("tbl%0d_gnt", k), g0, tbl[k].gnt);
      chk($sformatf("tbl%0d_vld", k), v0, tbl[k].vld);
      chk($sformatf("tbl%0d_idx", k), i0, tbl[k].idx);
    end
    r0 = '0;

    // T2: MAX_HOLD=1, all requesting -> strict one-cycle rotation
    t2_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rst_n = 1'b0; r1 = 4'b1111;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("t2_gnt%0d", k), g1, t2_exp[k]);
    end
    r1 = '0;

    // T5: MAX_HOLD=0, owner 1 holds while 2 waits, until it releases
    r2 = 4'b0110;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("t5_hold%0d", k), g2, 4'b0010);
    end
    r2 = 4'b0100;
    @(negedge clk);
    chk("t5_handoff", g2, 4'b0100);
    chk("t5_handoff_idx", i2, 2'd2);
    r2 = '0;

    // T7: random parameter sweep
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rnd_en = 1'b1;
    repeat (10000) @(negedge clk);
    rnd_en = 1'b0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
